// File: rtl/pkt_gen.sv
// ----------------------------------------------------------------------------
// pkt_gen
//   Multi-channel packet traffic source. Each channel, on a start pulse,
//   emits one complete packet on its own write lane:
//     SOP    : wr_sop=1, no data
//     HDR    : wr_vld=1, data = zero-extended {len, prio, dest}
//     PAY xN : wr_vld=1, data = zero-extended {seq[15:0], ch[7:0], k}, k=1..len
//     EOP    : wr_eop=1, done=1, no data
//   A packet may only begin on an edge where full=0. Once the packet has
//   started, full no longer affects it.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   start      : per-channel one-cycle packet request
//   cfg_dest   : per-channel dest field, latched when start is accepted
//   cfg_prio   : per-channel priority field, latched when start is accepted
//   cfg_len    : per-channel payload word count, latched when start is accepted
//   full       : shared switch-full flag; holds off new packet starts
//   busy       : channel is not idle
//   done       : one-cycle pulse together with wr_eop
//   wr_sop     : start-of-packet marker
//   wr_eop     : end-of-packet marker
//   wr_vld     : data word valid
//   wr_data    : lane i is wr_data[i*data_width +: data_width]
//   dbg_state  : lane i is the 3-bit FSM state of channel i (for checkers)
//
// Handshake: there is no back-pressure. start is a request that is honoured
// only when the channel is IDLE or in its EOP cycle and otherwise dropped.
// wr_sop / wr_vld / wr_eop are one-hot (or all zero) on every cycle; the
// consumer must accept every word the cycle it is presented.
// ----------------------------------------------------------------------------
module pkt_gen #(
    parameter int num_of_ports   = 16,
    parameter int data_width     = 64,
    parameter int dest_width     = 4,
    parameter int priority_width = 3,
    parameter int len_width      = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [num_of_ports-1:0]                start,
    input  logic [num_of_ports*dest_width-1:0]     cfg_dest,
    input  logic [num_of_ports*priority_width-1:0] cfg_prio,
    input  logic [num_of_ports*len_width-1:0]      cfg_len,
    input  logic                                   full,
    output logic [num_of_ports-1:0]                busy,
    output logic [num_of_ports-1:0]                done,
    output logic [num_of_ports-1:0]                wr_sop,
    output logic [num_of_ports-1:0]                wr_eop,
    output logic [num_of_ports-1:0]                wr_vld,
    output logic [num_of_ports*data_width-1:0]     wr_data,
    output logic [num_of_ports*3-1:0]              dbg_state
);

    // Channel FSM encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_SOP  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_EOP  = 3'd5;

    localparam int SEQ_W = 16;
    localparam int CH_W  = 8;
    localparam int HDR_W = dest_width + priority_width + len_width;
    localparam int PAY_W = SEQ_W + CH_W + len_width;

    for (genvar g = 0; g < num_of_ports; g++) begin : g_ch

        localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

        logic [2:0]                state_q, state_d;
        logic [dest_width-1:0]     dest_q,  dest_d;
        logic [priority_width-1:0] prio_q,  prio_d;
        logic [len_width-1:0]      len_q,   len_d;
        logic [len_width-1:0]      cnt_q,   cnt_d;
        logic [SEQ_W-1:0]          seq_q,   seq_d;
        logic                      accept;

        // Header and payload words before fitting to data_width. The wide
        // extension lets the same slice either zero-extend or truncate.
        logic [HDR_W-1:0]            hdr_word;
        logic [PAY_W-1:0]            pay_word;
        logic [HDR_W+data_width-1:0] hdr_ext;
        logic [PAY_W+data_width-1:0] pay_ext;
        logic [data_width-1:0]       data_lane;

        // --------------------------------------------------------------------
        // Next-state logic
        // --------------------------------------------------------------------
        always_comb begin
            state_d = state_q;
            dest_d  = dest_q;
            prio_d  = prio_q;
            len_d   = len_q;
            cnt_d   = cnt_q;
            seq_d   = seq_q;

            // EOP also accepts a new start so packets can run back-to-back.
            accept = start[g] && ((state_q == S_IDLE) || (state_q == S_EOP));

            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_WAIT: begin
                    if (!full) begin
                        state_d = S_SOP;
                    end
                end
                S_SOP:  state_d = S_HDR;
                S_HDR: begin
                    if (len_q != '0) begin
                        state_d = S_PAY;
                        cnt_d   = len_width'(1);
                    end else begin
                        state_d = S_EOP;
                    end
                end
                S_PAY: begin
                    // cnt_q is the index of the word on the bus this cycle
                    if (cnt_q == len_q) begin
                        state_d = S_EOP;
                    end else begin
                        cnt_d = cnt_q + len_width'(1);
                    end
                end
                S_EOP: begin
                    state_d = S_IDLE;
                    seq_d   = seq_q + SEQ_W'(1);
                end
                default: state_d = S_IDLE;
            endcase

            if (accept) begin
                dest_d  = cfg_dest[g*dest_width +: dest_width];
                prio_d  = cfg_prio[g*priority_width +: priority_width];
                len_d   = cfg_len[g*len_width +: len_width];
                state_d = full ? S_WAIT : S_SOP;
            end
        end

        // --------------------------------------------------------------------
        // State registers
        // --------------------------------------------------------------------
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                dest_q  <= '0;
                prio_q  <= '0;
                len_q   <= '0;
                cnt_q   <= '0;
                seq_q   <= '0;
            end else begin
                state_q <= state_d;
                dest_q  <= dest_d;
                prio_q  <= prio_d;
                len_q   <= len_d;
                cnt_q   <= cnt_d;
                seq_q   <= seq_d;
            end
        end

        // --------------------------------------------------------------------
        // Moore output decode: registered state only, so reset clears the
        // lane immediately and no input reaches an output combinationally.
        // --------------------------------------------------------------------
        assign hdr_word = {len_q, prio_q, dest_q};
        assign pay_word = {seq_q, CH_IDX, cnt_q};
        assign hdr_ext  = {{data_width{1'b0}}, hdr_word};
        assign pay_ext  = {{data_width{1'b0}}, pay_word};

        always_comb begin
            data_lane = '0;
            case (state_q)
                S_HDR:   data_lane = hdr_ext[data_width-1:0];
                S_PAY:   data_lane = pay_ext[data_width-1:0];
                default: data_lane = '0;
            endcase
        end

        assign busy[g]   = (state_q != S_IDLE);
        assign wr_sop[g] = (state_q == S_SOP);
        assign wr_vld[g] = (state_q == S_HDR) || (state_q == S_PAY);
        assign wr_eop[g] = (state_q == S_EOP);
        assign done[g]   = (state_q == S_EOP);

        assign wr_data[g*data_width +: data_width] = data_lane;
        assign dbg_state[g*3 +: 3]                 = state_q;
    end

endmodule

// File: tb/tb_pkt_gen.sv
// ----------------------------------------------------------------------------
// tb_pkt_gen
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model turns every accepted request into the list of beats the packet
//   should produce and plays them out one per cycle; every cycle all lanes
//   are compared against it.
// ----------------------------------------------------------------------------
module tb_pkt_gen;

    localparam int NP    = 16;
    localparam int DW    = 64;
    localparam int DESTW = 4;
    localparam int PW    = 3;
    localparam int LW    = 8;
    // beat = {sop, vld, eop, data}
    localparam int BW    = DW + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]       start    = '0;
    logic [NP*DESTW-1:0] cfg_dest = '0;
    logic [NP*PW-1:0]    cfg_prio = '0;
    logic [NP*LW-1:0]    cfg_len  = '0;
    logic                full     = 1'b0;

    logic [NP-1:0]    busy, done, wr_sop, wr_eop, wr_vld;
    logic [NP*DW-1:0] wr_data;
    logic [NP*3-1:0]  dbg_state;

    pkt_gen #(
        .num_of_ports  (NP),
        .data_width    (DW),
        .dest_width    (DESTW),
        .priority_width(PW),
        .len_width     (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_dest (cfg_dest),
        .cfg_prio (cfg_prio),
        .cfg_len  (cfg_len),
        .full     (full),
        .busy     (busy),
        .done     (done),
        .wr_sop   (wr_sop),
        .wr_eop   (wr_eop),
        .wr_vld   (wr_vld),
        .wr_data  (wr_data),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_chk  = 0;
    int n_pass = 0;

    logic [BW-1:0]    exp_q[NP][$];   // beats still to be played per channel
    logic [BW-1:0]    mcur[NP];       // beat expected this cycle
    bit               mcur_v[NP];
    bit               mwait[NP];      // request held off by full
    logic [15:0]      mseq[NP];
    logic [DESTW-1:0] mdest[NP];
    logic [PW-1:0]    mprio[NP];
    logic [LW-1:0]    mlen[NP];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            exp_q[i].delete();
            mcur[i]   = '0;
            mcur_v[i] = 1'b0;
            mwait[i]  = 1'b0;
            mseq[i]   = '0;
            mdest[i]  = '0;
            mprio[i]  = '0;
            mlen[i]   = '0;
        end
    endtask

    // Queue every beat of one packet for channel i.
    task automatic push_pkt(input int i);
        logic [DW-1:0] w;
        exp_q[i].push_back({1'b1, 1'b0, 1'b0, {DW{1'b0}}});
        w = (DW'(mlen[i]) << (DESTW + PW)) | (DW'(mprio[i]) << DESTW) | DW'(mdest[i]);
        exp_q[i].push_back({1'b0, 1'b1, 1'b0, w});
        for (int k = 1; k <= int'(mlen[i]); k++) begin
            w = (DW'(mseq[i]) << (8 + LW)) | (DW'(i) << LW) | DW'(k);
            exp_q[i].push_back({1'b0, 1'b1, 1'b0, w});
        end
        exp_q[i].push_back({1'b0, 1'b0, 1'b1, {DW{1'b0}}});
    endtask

    // Advance the model by one rising edge using the inputs the DUT sees.
    task automatic model_edge();
        bit in_eop, idle;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NP; i++) begin
            in_eop = mcur_v[i] && mcur[i][DW];
            idle   = !mcur_v[i] && !mwait[i];
            if (in_eop) mseq[i] = mseq[i] + 16'd1;
            if (mwait[i]) begin
                if (!full) begin
                    mwait[i] = 1'b0;
                    push_pkt(i);
                end
            end else if (start[i] && (idle || (in_eop && exp_q[i].size() == 0))) begin
                mdest[i] = cfg_dest[i*DESTW +: DESTW];
                mprio[i] = cfg_prio[i*PW +: PW];
                mlen[i]  = cfg_len[i*LW +: LW];
                if (full) mwait[i] = 1'b1;
                else      push_pkt(i);
            end
            if (exp_q[i].size() > 0) begin
                mcur[i]   = exp_q[i].pop_front();
                mcur_v[i] = 1'b1;
            end else begin
                mcur[i]   = '0;
                mcur_v[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] e_busy, e_sop, e_eop, e_vld;
        for (int i = 0; i < NP; i++) begin
            e_busy[i] = mwait[i] || mcur_v[i];
            e_sop[i]  = mcur_v[i] && mcur[i][DW+2];
            e_vld[i]  = mcur_v[i] && mcur[i][DW+1];
            e_eop[i]  = mcur_v[i] && mcur[i][DW];
        end
        chk("busy",   64'(busy),   64'(e_busy));
        chk("wr_sop", 64'(wr_sop), 64'(e_sop));
        chk("wr_vld", 64'(wr_vld), 64'(e_vld));
        chk("wr_eop", 64'(wr_eop), 64'(e_eop));
        chk("done",   64'(done),   64'(e_eop));
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("wr_data[%0d]", i), wr_data[i*DW +: DW],
                mcur_v[i] ? mcur[i][DW-1:0] : {DW{1'b0}});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic set_cfg(input int ch, input int d, input int p, input int l);
        cfg_dest[ch*DESTW +: DESTW] = DESTW'(d);
        cfg_prio[ch*PW +: PW]       = PW'(p);
        cfg_len[ch*LW +: LW]        = LW'(l);
    endtask

    // Reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        compare_all();
        steps(2);
        rst = 1'b0;
        step();

        // ch0: dest 0, prio 0, len 4
        set_cfg(0, 0, 0, 4);
        start[0] = 1'b1;
        step();
        start = '0;
        chk("t1_sop", 64'(wr_sop[0]), 64'd1);
        step();
        chk("t1_hdr", wr_data[0 +: DW], 64'h200);
        step();
        chk("t1_pay1", wr_data[0 +: DW], 64'h1);
        steps(3);
        chk("t1_pay4", wr_data[0 +: DW], 64'h4);
        step();
        chk("t1_eop", 64'(wr_eop[0]), 64'd1);
        chk("t1_done", 64'(done[0]), 64'd1);
        step();
        chk("t1_idle", 64'(busy[0]), 64'd0);

        // ch3: dest 5, prio 7, len 0
        set_cfg(3, 5, 7, 0);
        start[3] = 1'b1;
        step();
        start = '0;
        step();
        chk("t2_hdr", wr_data[3*DW +: DW], 64'h75);
        step();
        chk("t2_eop", 64'(wr_eop[3]), 64'd1);
        step();

        // ch1 held off by full, full raised again mid-payload
        full = 1'b1;
        set_cfg(1, 2, 3, 2);
        start[1] = 1'b1;
        step();
        start = '0;
        chk("t3_busy_wait", 64'(busy[1]), 64'd1);
        chk("t3_no_sop", 64'(wr_sop[1]), 64'd0);
        steps(2);
        full = 1'b0;
        step();
        chk("t3_sop", 64'(wr_sop[1]), 64'd1);
        full = 1'b1;
        steps(3);
        chk("t3_pay2", 64'(wr_vld[1]), 64'd1);
        step();
        chk("t3_eop", 64'(wr_eop[1]), 64'd1);
        full = 1'b0;
        step();

        // ch2: start in PAY ignored, start in EOP runs back-to-back
        set_cfg(2, 1, 1, 1);
        start[2] = 1'b1;
        step();
        start = '0;
        steps(2);
        start[2] = 1'b1;     // in PAY now: must be dropped
        step();
        chk("t4_eop", 64'(wr_eop[2]), 64'd1);
        step();              // still high during EOP: accepted
        start = '0;
        chk("t4_sop2", 64'(wr_sop[2]), 64'd1);
        steps(2);
        chk("t4_pay_seq1", wr_data[2*DW +: DW], 64'h10201);
        steps(2);
        chk("t4_idle", 64'(busy[2]), 64'd0);

        // reset in the middle of a ch0 payload
        set_cfg(0, 3, 2, 10);
        start[0] = 1'b1;
        step();
        start = '0;
        steps(3);
        async_reset();
        chk("t5_vld_cleared", 64'(wr_vld), 64'd0);
        set_cfg(0, 0, 0, 1);
        start[0] = 1'b1;
        step();
        start = '0;
        steps(2);
        chk("t5_pay_seq0", wr_data[0 +: DW], 64'h1);
        steps(2);

        // all channels at once, differing lengths
        for (int i = 0; i < NP; i++) set_cfg(i, i, i % 8, i + 1);
        start = '1;
        step();
        start = '0;
        steps(22);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                start[i] = ($urandom_range(0, 7) == 0);
                set_cfg(i, $urandom_range(0, 15), $urandom_range(0, 7),
                        ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255)
                                                     : $urandom_range(0, 12));
            end
            full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) async_reset();
            else step();
        end
        start = '0;
        full  = 1'b0;
        steps(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
